mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single data-memory port.
// Optional WAIT timeout enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rq0_req,
  input  logic                    rq1_req,
  input  logic                    rq0_we,
  input  logic                    rq1_we,
  input  logic [ADDRESS_BITS-1:0] rq0_addr,
  input  logic [ADDRESS_BITS-1:0] rq1_addr,
  input  logic [DATA_WIDTH-1:0]   rq0_wdata,
  input  logic [DATA_WIDTH-1:0]   rq1_wdata,
  output logic                    rq0_done,
  output logic                    rq1_done,
  output logic [DATA_WIDTH-1:0]   rq_rdata,
  output logic                    rq_err,
  output logic                    mem_load,
  output logic                    mem_store,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_store_data,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_load_data,
  output logic                    grant,
  output logic                    busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // Reject out-of-range timeout settings at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_to_chk
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  logic [1:0]              state_q, state_d;
  logic                    last_q, last_d;
  logic                    grant_q, grant_d;
  logic                    we_q, we_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    done0_q, done0_d;
  logic                    done1_q, done1_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
`endif

  // Next-state, arbitration and completion logic.
  always_comb begin
    logic owner;
    owner   = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    rdata_d = '0;
`ifdef ARB_TIMEOUT_EN
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rq0_req || rq1_req) begin
          owner   = (rq0_req && rq1_req) ? ~last_q : rq1_req;
          grant_d = owner;
          last_d  = owner;
          we_d    = owner ? rq1_we    : rq0_we;
          addr_d  = owner ? rq1_addr  : rq0_addr;
          wdata_d = owner ? rq1_wdata : rq0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          if (we_q) begin
            done0_d = ~grant_q;
            done1_d = grant_q;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      WAIT: begin
        if (mem_valid) begin
          rdata_d = mem_load_data;
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      rdata_q <= rdata_d;
`ifdef ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Strobes come straight from state so WAIT/IDLE never drive the port.
  always_comb begin
    mem_load       = (state_q == ISSUE) && !we_q;
    mem_store      = (state_q == ISSUE) && we_q;
    mem_address    = addr_q;
    mem_store_data = wdata_q;
    rq0_done       = done0_q;
    rq1_done       = done1_q;
    rq_rdata       = rdata_q;
    grant          = grant_q;
    busy           = (state_q != IDLE);
`ifdef ARB_TIMEOUT_EN
    rq_err         = err_q;
`else
    rq_err         = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a done-pulse scoreboard.
// Expected completions are queued by stimulus and popped by the monitor.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        rq0_req, rq1_req, rq0_we, rq1_we;
  logic [19:0] rq0_addr, rq1_addr;
  logic [31:0] rq0_wdata, rq1_wdata;
  logic        rq0_done, rq1_done;
  logic [31:0] rq_rdata;
  logic        rq_err;
  logic        mem_load, mem_store;
  logic [19:0] mem_address;
  logic [31:0] mem_store_data;
  logic        mem_ready, mem_valid;
  logic [31:0] mem_load_data;
  logic        grant, busy;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   accepts = 0;

  mem_port_arbiter #(
    .DATA_WIDTH(32),
    .ADDRESS_BITS(20),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset),
    .rq0_req(rq0_req), .rq1_req(rq1_req),
    .rq0_we(rq0_we), .rq1_we(rq1_we),
    .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
    .rq0_wdata(rq0_wdata), .rq1_wdata(rq1_wdata),
    .rq0_done(rq0_done), .rq1_done(rq1_done),
    .rq_rdata(rq_rdata), .rq_err(rq_err),
    .mem_load(mem_load), .mem_store(mem_store),
    .mem_address(mem_address),
    .mem_store_data(mem_store_data),
    .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_load_data(mem_load_data),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic p,
                      input logic [31:0] d,
                      input logic e);
    exp_t x;
    x.port = p;
    x.rdata = d;
    x.err = e;
    q.push_back(x);
  endtask

  // Accepted accesses: a strobe seen together with mem_ready.
  always @(posedge clock)
    if (reset && (mem_load || mem_store) && mem_ready)
      accepts++;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (mem_load && mem_store)
      chk("both_strobes", 1, 0);
    if (rq0_done && rq1_done)
      chk("both_done", 1, 0);
    if (rq0_done || rq1_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_port", 64'(rq1_done), 64'(e.port));
        chk("done_rdata", 64'(rq_rdata), 64'(e.rdata));
        chk("done_err", 64'(rq_err), 64'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int acc0;
    reset = 1'b0;
    rq0_req = 0; rq1_req = 0; rq0_we = 0; rq1_we = 0;
    rq0_addr = '0; rq1_addr = '0;
    rq0_wdata = '0; rq1_wdata = '0;
    mem_ready = 0; mem_valid = 0; mem_load_data = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_grant", 64'(grant), 0);
    chk("rst_strobes", 64'({mem_load, mem_store}), 0);
    chk("rst_addr", 64'(mem_address), 0);
    chk("rst_sdata", 64'(mem_store_data), 0);
    chk("rst_done", 64'({rq0_done, rq1_done}), 0);
    chk("rst_rdata_err", 64'({rq_rdata, rq_err}), 0);
    reset = 1'b1;

    // mem_valid while idle is ignored
    mem_valid = 1; mem_load_data = 32'hAAAA5555;
    tick();
    tick();
    mem_valid = 0;
    chk("idle_valid_busy", 64'(busy), 0);

    // single store from rq0
    rq0_req = 1; rq0_we = 1;
    rq0_addr = 20'h00100; rq0_wdata = 32'hDEADBEEF;
    mem_ready = 1;
    push(0, 32'h0, 0);
    tick();
    chk("st_strobe", 64'({mem_load, mem_store}), 64'b01);
    chk("st_addr", 64'(mem_address), 64'h00100);
    chk("st_data", 64'(mem_store_data), 64'hDEADBEEF);
    chk("st_grant_busy", 64'({grant, busy}), 64'b01);
    rq0_req = 0;
    tick();
    chk("st_done", 64'({rq0_done, rq1_done}), 64'b10);
    chk("st_strobe_off", 64'(mem_store), 0);
    tick();
    chk("st_done_pulse", 64'(rq0_done), 0);

    // load from rq1 with mem_valid three cycles after issue
    rq1_req = 1; rq1_we = 0; rq1_addr = 20'h00040;
    push(1, 32'h12345678, 0);
    tick();
    chk("ld_strobe", 64'({mem_load, mem_store}), 64'b10);
    chk("ld_addr", 64'(mem_address), 64'h00040);
    chk("ld_grant", 64'(grant), 1);
    rq1_req = 0;
    tick();
    chk("ld_wait_strobe", 64'({mem_load, busy}), 64'b01);
    tick();
    mem_valid = 1; mem_load_data = 32'h12345678;
    tick();
    mem_valid = 0; mem_load_data = '0;
    chk("ld_done", 64'({rq0_done, rq1_done}), 64'b01);
    chk("ld_rdata", 64'(rq_rdata), 64'h12345678);
    tick();

    // contention: four transactions, both requests held
    do_reset();
    rq0_req = 1; rq0_we = 1; rq0_addr = 20'h00010;
    rq0_wdata = 32'h0000000A;
    rq1_req = 1; rq1_we = 1; rq1_addr = 20'h00020;
    rq1_wdata = 32'h0000000B;
    mem_ready = 1;
    push(0, 0, 0); push(1, 0, 0);
    push(0, 0, 0); push(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant", 64'(grant), 64'(i % 2));
      chk("rr_addr", 64'(mem_address),
          (i % 2) ? 64'h20 : 64'h10);
      tick();
    end
    rq0_req = 0; rq1_req = 0;
    tick();

    // back-pressure: five cycles of mem_ready low in ISSUE
    acc0 = accepts;
    rq0_req = 1; rq0_we = 1; rq0_addr = 20'h00300;
    rq0_wdata = 32'hCAFEF00D;
    mem_ready = 0;
    push(0, 0, 0);
    tick();
    rq0_req = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 64'({mem_store, mem_address}),
          64'({1'b1, 20'h00300}));
      tick();
    end
    mem_ready = 1;
    tick();
    chk("bp_done", 64'(rq0_done), 1);
    chk("bp_accepts", 64'(accepts - acc0), 1);
    tick();

    // reset while waiting for load data
    rq1_req = 1; rq1_we = 0; rq1_addr = 20'h00044;
    tick();
    rq1_req = 0;
    tick();
    chk("rw_in_wait", 64'(busy), 1);
    reset = 0;
    tick();
    chk("rw_busy", 64'(busy), 0);
    chk("rw_outs", 64'({mem_load, mem_store, grant,
        rq0_done, rq1_done, rq_err}), 0);
    chk("rw_addr", 64'(mem_address), 0);
    reset = 1;
    mem_valid = 1; mem_load_data = 32'h55;
    tick();
    mem_valid = 0;
    tick();
    chk("rw_no_done", 64'({rq0_done, rq1_done}), 0);

`ifdef ARB_TIMEOUT_EN
    // load with no mem_valid times out after four WAIT cycles
    rq0_req = 1; rq0_we = 0; rq0_addr = 20'h00080;
    push(0, 0, 1);
    tick();
    rq0_req = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_pending", 64'({busy, rq0_done}), 64'b10);
    end
    tick();
    chk("to_done", 64'({rq0_done, rq_err}), 64'b11);
    mem_valid = 1; mem_load_data = 32'h77;
    tick();
    mem_valid = 0;
    tick();
`endif

    tick();
    chk("queue_empty", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
